// File: rtl/reg_load_arbiter_if.sv
// Shared control-port bundle between the requesters and the register arbiter.
// The requester side drives REQ/DIN/CLR_REQ; the arbiter drives the register strobes.
interface reg_load_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic [N-1:0]   REQ;
    logic [N*W-1:0] DIN;
    logic           CLR_REQ;
    logic [N-1:0]   GNT;
    logic           L;
    logic           R;
    logic [W-1:0]   D;
    logic           BUSY;

    modport master (
        output REQ, DIN, CLR_REQ,
        input  GNT, L, R, D, BUSY
    );

    modport slave (
        input  REQ, DIN, CLR_REQ,
        output GNT, L, R, D, BUSY
    );
endinterface

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter for the R/L/D port of one register.
// Clear beats load; every grant gives one load pulse, then holds until REQ drops.
module reg_load_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input logic              CLK,
    input logic              RST,
    reg_load_arbiter_if.slave bus
);
    localparam int PW = $clog2(N);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CLEAR     = 2'd1;
    localparam logic [1:0] LOAD      = 2'd2;
    localparam logic [1:0] WAIT_DROP = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          hit;
    int            idx;
    logic [N-1:0]  win_oh;
    logic [W-1:0]  win_d;
    logic [PW-1:0] ptr_nxt;
    logic          held;

    // First set request scanning upward from ptr, wrapping at N.
    always_comb begin
        win = '0;
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!hit && bus.REQ[idx]) begin
                hit = 1'b1;
                win = PW'(idx);
            end
        end
    end

    assign win_oh  = N'(1) << win;
    assign win_d   = bus.DIN[int'(win)*W +: W];
    assign ptr_nxt = (win == PW'(N-1)) ? '0 : win + 1'b1;
    assign held    = |(bus.REQ & bus.GNT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            bus.GNT  <= '0;
            bus.L    <= 1'b0;
            bus.R    <= 1'b0;
            bus.D    <= '0;
            bus.BUSY <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CLR_REQ) begin
                        state    <= CLEAR;
                        bus.R    <= 1'b1;
                        bus.BUSY <= 1'b1;
                    end else if (hit) begin
                        state    <= LOAD;
                        bus.GNT  <= win_oh;
                        bus.L    <= 1'b1;
                        bus.D    <= win_d;
                        bus.BUSY <= 1'b1;
                        ptr      <= ptr_nxt;
                    end
                end
                CLEAR: begin
                    state    <= IDLE;
                    bus.R    <= 1'b0;
                    bus.BUSY <= 1'b0;
                end
                LOAD: begin
                    state <= WAIT_DROP;
                    bus.L <= 1'b0;
                    bus.D <= '0;
                end
                WAIT_DROP: begin
                    if (!held) begin
                        state    <= IDLE;
                        bus.GNT  <= '0;
                        bus.BUSY <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.GNT  <= '0;
                    bus.L    <= 1'b0;
                    bus.R    <= 1'b0;
                    bus.D    <= '0;
                    bus.BUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter with a simple attached register model.
// Outputs are packed as {GNT, L, R, D, BUSY} and sampled on the falling edge.
module tb_reg_load_arbiter;
    logic CLK = 1'b0;
    logic RST;
    logic [3:0] reg_q = '0;
    int checks   = 0;
    int failures = 0;
    logic [10:0] obs;
    logic [10:0] exp;

    reg_load_arbiter_if #(.N(4), .W(4)) bus ();

    reg_load_arbiter #(.N(4), .W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) begin
        if (bus.R)      reg_q <= '0;
        else if (bus.L) reg_q <= bus.D;
    end

    function automatic logic [10:0] pk(logic [3:0] g, logic l, logic r,
                                       logic [3:0] d, logic b);
        return {g, l, r, d, b};
    endfunction

    function automatic logic [10:0] cur();
        return {bus.GNT, bus.L, bus.R, bus.D, bus.BUSY};
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.REQ = '0;
        bus.DIN = '0;
        bus.CLR_REQ = 1'b0;
        tick();
        tick();
        exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", obs, exp);
        end
        RST = 1'b0;
        bus.REQ = 4'b0001;
        bus.DIN = 16'h0009;
        tick();
        exp = pk(4'b0001, 1, 0, 4'h9, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_pre_load got=%h exp=%h", obs, exp);
        end
        #2 RST = 1'b1;
        #1;
        exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", obs, exp);
        end
        @(negedge CLK);
        exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", obs, exp);
        end
        RST = 1'b0;
        tick();
        exp = pk(4'b0001, 1, 0, 4'h9, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_regrant got=%h exp=%h", obs, exp);
        end
        bus.REQ = '0;
        tick();
        tick();
        exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_single();
        bus.REQ = 4'b0100;
        bus.DIN = 16'h0A00;
        tick();
        exp = pk(4'b0100, 1, 0, 4'hA, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_load got=%h exp=%h", obs, exp);
        end
        tick();
        exp = pk(4'b0100, 0, 0, 4'h0, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_hold got=%h exp=%h", obs, exp);
        end
        checks++;
        if (reg_q !== 4'hA) begin
            failures++;
            $display("FAIL single_reg got=%h exp=%h", reg_q, 4'hA);
        end
        tick();
        exp = pk(4'b0100, 0, 0, 4'h0, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_hold2 got=%h exp=%h", obs, exp);
        end
        bus.REQ = '0;
        tick();
        exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_drop got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        do_reset();
        bus.REQ = 4'b1111;
        bus.DIN = 16'h4321;
        for (int i = 0; i < 4; i++) begin
            g = 4'b0001 << i;
            tick();
            exp = pk(g, 1, 0, 4'(i + 1), 1); obs = cur(); checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rr_grant%0d got=%h exp=%h", i, obs, exp);
            end
            tick();
            bus.REQ[i] = 1'b0;
            tick();
            exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rr_idle%0d got=%h exp=%h", i, obs, exp);
            end
        end
        bus.REQ = 4'b1111;
        tick();
        exp = pk(4'b0001, 1, 0, 4'h1, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL rr_wrap got=%h exp=%h", obs, exp);
        end
        bus.REQ = '0;
        tick();
        tick();
    endtask

    task automatic test_priority();
        bus.DIN = 16'h00B0;
        bus.CLR_REQ = 1'b1;
        bus.REQ = 4'b0010;
        tick();
        exp = pk(4'b0000, 0, 1, 4'h0, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL prio_clear got=%h exp=%h", obs, exp);
        end
        bus.CLR_REQ = 1'b0;
        tick();
        exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL prio_after got=%h exp=%h", obs, exp);
        end
        checks++;
        if (reg_q !== 4'h0) begin
            failures++;
            $display("FAIL prio_reg got=%h exp=%h", reg_q, 4'h0);
        end
        tick();
        exp = pk(4'b0010, 1, 0, 4'hB, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL prio_grant got=%h exp=%h", obs, exp);
        end
        bus.REQ = '0;
        tick();
        tick();
    endtask

    task automatic test_clear_hold();
        bus.REQ = 4'b1000;
        bus.DIN = 16'hC000;
        tick();
        exp = pk(4'b1000, 1, 0, 4'hC, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_grant got=%h exp=%h", obs, exp);
        end
        tick();
        bus.CLR_REQ = 1'b1;
        tick();
        tick();
        exp = pk(4'b1000, 0, 0, 4'h0, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_no_r got=%h exp=%h", obs, exp);
        end
        bus.REQ = '0;
        tick();
        exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_drop got=%h exp=%h", obs, exp);
        end
        tick();
        exp = pk(4'b0000, 0, 1, 4'h0, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_clear got=%h exp=%h", obs, exp);
        end
        bus.CLR_REQ = 1'b0;
        tick();
        exp = pk(4'b0000, 0, 0, 4'h0, 0); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_done got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_data_freeze();
        bus.REQ = 4'b0001;
        bus.DIN = 16'h0005;
        tick();
        bus.DIN = 16'h000F;
        #1;
        exp = pk(4'b0001, 1, 0, 4'h5, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL freeze_d got=%h exp=%h", obs, exp);
        end
        tick();
        exp = pk(4'b0001, 0, 0, 4'h0, 1); obs = cur(); checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL freeze_hold got=%h exp=%h", obs, exp);
        end
        checks++;
        if (reg_q !== 4'h5) begin
            failures++;
            $display("FAIL freeze_reg got=%h exp=%h", reg_q, 4'h5);
        end
        bus.REQ = '0;
        tick();
        checks++;
        if (reg_q !== 4'h5) begin
            failures++;
            $display("FAIL freeze_reg_keep got=%h exp=%h", reg_q, 4'h5);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_clear_hold();
        test_data_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
